pc_seq_ctrl: RTL and testbench

// Sequences the program counter register for the 32b MIPS core.

---
 rtl/pc_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 22 ++
 rtl/pc_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC sequencing controller: FSM state encoding and PC source selects.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        FLUSH,
        HALTED,
        STEP
    } pc_state_t;

    typedef logic [1:0] pc_src_t;

    localparam pc_src_t PCS_SEQ  = 2'b00;
    localparam pc_src_t PCS_BR   = 2'b01;
    localparam pc_src_t PCS_JMP  = 2'b10;
    localparam pc_src_t PCS_HOLD = 2'b11;

    // Compares the word index of a byte address against a halt word address.
    function automatic logic is_halt_pc(input logic [31:0] pc, input logic [29:0] halt_word);
        return (pc >> 2) == {2'b00, halt_word};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: arbitrates stalls, redirects, fetch backpressure and debug
// halt/step to drive the PC write enable and source select, plus pipeline flush pulses.
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_WAIT = 2,
    parameter int unsigned FLUSH_CYC = 1,
    parameter bit          HALT_EN   = 1'b1,
    parameter int unsigned HALT_PC   = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_det,
    input  logic             br_taken,
    input  logic             jump_ctrl,
    input  logic [31:0]      next_pc,
    input  logic             imem_ready,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             fetch_vld,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [15:0] BOOT_INIT = 16'(BOOT_WAIT);
    localparam logic [2:0]  BUB_INIT  = 3'(FLUSH_CYC - 1);
    localparam logic [29:0] HALT_WORD = 30'(HALT_PC);

    pc_state_t   state, next_state;
    logic [15:0] boot_cnt;
    logic [2:0]  bub_cnt;
    logic        from_step;

    pc_src_t     rule_src;
    logic        rule_we, rule_redir, rule_halt;
    logic        redir_inc, stall_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            boot_cnt  <= BOOT_INIT;
            bub_cnt   <= '0;
            from_step <= 1'b0;
        end else begin
            state <= next_state;
            if (state == BOOT && boot_cnt != '0) begin
                boot_cnt <= boot_cnt - 16'd1;
            end
            // Remember whether the flush came from a debug step so it can return to HALTED.
            if (next_state == FLUSH && state != FLUSH) begin
                bub_cnt   <= BUB_INIT;
                from_step <= (state == STEP);
            end else if (state == FLUSH && bub_cnt != '0) begin
                bub_cnt <= bub_cnt - 3'd1;
            end
        end
    end

    // Normal-flow arbitration shared by RUN and STEP; jump outranks branch.
    always_comb begin
        rule_src   = PCS_SEQ;
        rule_we    = 1'b1;
        rule_redir = 1'b0;
        if (jump_ctrl) begin
            rule_src   = PCS_JMP;
            rule_redir = 1'b1;
        end else if (br_taken) begin
            rule_src   = PCS_BR;
            rule_redir = 1'b1;
        end else if (hazard_det || !imem_ready) begin
            rule_src = PCS_HOLD;
            rule_we  = 1'b0;
        end
        rule_halt = HALT_EN && rule_we && is_halt_pc(next_pc, HALT_WORD);
    end

    always_comb begin
        next_state = state;
        pc_we      = 1'b0;
        pc_src     = PCS_HOLD;
        redir_inc  = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            BOOT: begin
                if (boot_cnt == '0) next_state = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    next_state = HALTED;
                end else begin
                    pc_src    = rule_src;
                    pc_we     = rule_we;
                    redir_inc = rule_redir;
                    stall_inc = !rule_we;
                    if (rule_halt)       next_state = HALTED;
                    else if (rule_redir) next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (bub_cnt == '0) next_state = from_step ? HALTED : RUN;
            end
            HALTED: begin
                if (resume_req)    next_state = RUN;
                else if (step_req) next_state = STEP;
            end
            STEP: begin
                if (imem_ready) begin
                    pc_src     = rule_src;
                    pc_we      = rule_we;
                    redir_inc  = rule_redir;
                    next_state = (rule_redir && !rule_halt) ? FLUSH : HALTED;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    assign fetch_vld   = (state == RUN) || (state == FLUSH) || (state == STEP);
    assign flush_if_id = (state == FLUSH);
    assign flush_id_ex = (state == FLUSH) && (bub_cnt == BUB_INIT);
    assign halted      = (state == HALTED);

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redir_inc),
        .clr (1'b0),
        .cnt (redir_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: table of per-cycle vectors through a scoreboard, plus hand
// sequences for async reset, multi-cycle flush and counter saturation.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_det, br_taken, jump_ctrl, imem_ready, halt_req, step_req, resume_req;
    logic [31:0] next_pc;

    logic        pc_we, fetch_vld, flush_if_id, flush_id_ex, halted;
    logic [1:0]  pc_src;
    logic [15:0] redir_cnt, stall_cnt;

    logic        s_pc_we, s_fetch_vld, s_flush_if_id, s_flush_id_ex, s_halted;
    logic [1:0]  s_pc_src;
    logic [3:0]  s_redir_cnt, s_stall_cnt;

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .BOOT_WAIT (2),
        .FLUSH_CYC (1),
        .HALT_EN   (1'b1),
        .HALT_PC   (5),
        .CNT_W     (16)
    ) dut (
        .clk (clk), .rst (rst), .hazard_det (hazard_det), .br_taken (br_taken),
        .jump_ctrl (jump_ctrl), .next_pc (next_pc), .imem_ready (imem_ready),
        .halt_req (halt_req), .step_req (step_req), .resume_req (resume_req),
        .pc_we (pc_we), .pc_src (pc_src), .fetch_vld (fetch_vld),
        .flush_if_id (flush_if_id), .flush_id_ex (flush_id_ex), .halted (halted),
        .redir_cnt (redir_cnt), .stall_cnt (stall_cnt)
    );

    pc_seq_ctrl #(
        .BOOT_WAIT (2),
        .FLUSH_CYC (3),
        .HALT_EN   (1'b0),
        .HALT_PC   (5),
        .CNT_W     (4)
    ) dut_sat (
        .clk (clk), .rst (rst), .hazard_det (hazard_det), .br_taken (br_taken),
        .jump_ctrl (jump_ctrl), .next_pc (next_pc), .imem_ready (imem_ready),
        .halt_req (halt_req), .step_req (step_req), .resume_req (resume_req),
        .pc_we (s_pc_we), .pc_src (s_pc_src), .fetch_vld (s_fetch_vld),
        .flush_if_id (s_flush_if_id), .flush_id_ex (s_flush_id_ex), .halted (s_halted),
        .redir_cnt (s_redir_cnt), .stall_cnt (s_stall_cnt)
    );

    // Packed view: {pc_we, pc_src, fetch_vld, flush_if_id, flush_id_ex, halted, stall, redir}
    typedef struct {
        logic        hz, br, jp, rdy, hr, sr, rr;
        logic [31:0] npc;
        logic [38:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [38:0] RESET_WORD = {1'b0, 2'b11, 4'b0000, 32'h0};

    function automatic vec_t mk(input logic hz, br, jp, rdy, hr, sr, rr, input logic [31:0] npc,
                                input logic we, input logic [1:0] src,
                                input logic fv, fif, fex, hlt, input int st, rd);
        vec_t v;
        v.hz = hz; v.br = br; v.jp = jp; v.rdy = rdy; v.hr = hr; v.sr = sr; v.rr = rr;
        v.npc = npc;
        v.exp = {we, src, fv, fif, fex, hlt, 16'(st), 16'(rd)};
        return v;
    endfunction

    function automatic logic [38:0] obs();
        return {pc_we, pc_src, fetch_vld, flush_if_id, flush_id_ex, halted, stall_cnt, redir_cnt};
    endfunction

    function automatic logic [38:0] obs_sat();
        return {s_pc_we, s_pc_src, s_fetch_vld, s_flush_if_id, s_flush_id_ex, s_halted,
                12'h0, s_stall_cnt, 12'h0, s_redir_cnt};
    endfunction

    task automatic chk(input string name, input logic [38:0] act, input logic [38:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle();
        hazard_det = 1'b0; br_taken = 1'b0; jump_ctrl = 1'b0; imem_ready = 1'b1;
        halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0; next_pc = 32'h0;
    endtask

    // Drives one vector just after a rising edge and scores it before the next one.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        hazard_det = v.hz; br_taken = v.br; jump_ctrl = v.jp; imem_ready = v.rdy;
        halt_req = v.hr; step_req = v.sr; resume_req = v.rr; next_pc = v.npc;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("vec%0d", idx), obs(), e.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 hz br jp rdy hr sr rr npc       we src  fv fif fex hlt st rd
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 0, 0, 0, 0, 0, 0)); // 0 boot
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 0, 0, 0, 0, 0, 0)); // 1 boot
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 0, 0, 0, 0, 0, 0)); // 2 boot
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 1, 2'b00, 1, 0, 0, 0, 0, 0)); // 3 run
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 1, 0, 0, 0, 0, 0)); // 4 hazard
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 1, 0, 0, 0, 1, 0)); // 5
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 1, 0, 0, 0, 2, 0)); // 6
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 1, 2'b00, 1, 0, 0, 0, 3, 0)); // 7
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h00, 0, 2'b11, 1, 0, 0, 0, 3, 0)); // 8 !ready
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 1, 2'b00, 1, 0, 0, 0, 4, 0)); // 9
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h40, 1, 2'b10, 1, 0, 0, 0, 4, 0)); // 10 jmp+br
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 1, 1, 1, 0, 4, 1)); // 11 flush
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 1, 2'b00, 1, 0, 0, 0, 4, 1)); // 12
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 32'h00, 1, 2'b01, 1, 0, 0, 0, 4, 1)); // 13 br
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h00, 0, 2'b11, 1, 1, 1, 0, 4, 2)); // 14 halt deferred
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h00, 0, 2'b11, 1, 0, 0, 0, 4, 2)); // 15 halt in run
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 16 halted
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h00, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 17 resume
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h14, 1, 2'b00, 1, 0, 0, 0, 4, 2)); // 18 halt pc
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 19 halted
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 20 step
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h18, 0, 2'b11, 1, 0, 0, 0, 4, 2)); // 21 step wait
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 1, 2'b00, 1, 0, 0, 0, 4, 2)); // 22 step go
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 23 halted
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 24 resume+halt
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h18, 0, 2'b11, 1, 0, 0, 0, 4, 2)); // 25 one run
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 26 re-halted
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 2)); // 27 step
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 32'h40, 1, 2'b10, 1, 0, 0, 0, 4, 2)); // 28 step jump
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 0, 2'b11, 1, 1, 1, 0, 4, 3)); // 29 flush
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 3)); // 30 halted
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h18, 0, 2'b11, 0, 0, 0, 1, 4, 3)); // 31 resume
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h18, 1, 2'b00, 1, 0, 0, 0, 4, 3)); // 32 run

        rst = 1'b1;
        idle();
        #2;
        chk("reset_state", obs(), RESET_WORD);
        chk("reset_state_sat", obs_sat(), RESET_WORD);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset in the middle of a flush bubble.
        idle();
        jump_ctrl = 1'b1;
        @(posedge clk);
        #1;
        jump_ctrl = 1'b0;
        chk("mid_flush", 39'(flush_if_id), 39'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", obs(), RESET_WORD);
        chk("async_reset_sat", obs_sat(), RESET_WORD);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three-bubble flush on the second instance.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("boot_done", 39'({fetch_vld, s_fetch_vld}), 39'(2'b11));
        jump_ctrl = 1'b1;
        @(posedge clk);
        #1;
        jump_ctrl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("flush3_cyc%0d", k), 39'({s_flush_if_id, s_flush_id_ex, s_pc_we}),
                39'({1'b1, (k == 0), 1'b0}));
            @(posedge clk);
            #1;
        end
        chk("flush3_exit", 39'({s_flush_if_id, s_fetch_vld, s_pc_we}), 39'(3'b011));
        chk("redir_after_reset", 39'({redir_cnt, 12'h0, s_redir_cnt}), 39'({16'd1, 12'h0, 4'd1}));

        // Stall counter saturation.
        hazard_det = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        chk("stall_15", 39'({stall_cnt, 12'h0, s_stall_cnt}), 39'({16'd15, 12'h0, 4'd15}));
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("stall_sat", 39'({stall_cnt, 12'h0, s_stall_cnt}), 39'({16'd20, 12'h0, 4'd15}));
        hazard_det = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
